// File: rtl/compare_checker.sv
// Stimulus/response bit comparator with settle masking, sticky per-bit errors and a
// saturating fail-cycle counter. Define COMPARE_FIRST_FAIL_EN to build first-fail capture.
module compare_checker #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned SETTLE = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             invert_i,
    input  logic             check_en_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] diff_o,
    output logic [WIDTH-1:0] err_sticky_o,
    output logic             fail_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic             checking_o,
    output logic             ff_valid_o,
    output logic [WIDTH-1:0] ff_a_o,
    output logic [WIDTH-1:0] ff_diff_o
);

    typedef enum logic [1:0] {StIdle, StSettle, StCheck} state_e;

    localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    // The chg cycle itself is already unchecked, so a reload covers SETTLE-1 further cycles.
    localparam logic [CntW-1:0] LoadIdle = CntW'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [CntW-1:0] LoadChg  = CntW'((SETTLE > 1) ? SETTLE - 2 : 0);
    localparam logic [CNT_W-1:0] CountMax = '1;

    logic [WIDTH-1:0] a_q, b_q, a_prev_q, diff_q, err_sticky_q, err_sticky_d;
    logic             inv_q, inv_prev_q;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    state_e           state_q, state_d;
    logic [WIDTH-1:0] m;
    logic             chg, upd;

    assign m   = a_q ^ b_q ^ {WIDTH{inv_q}};
    assign chg = (a_q != a_prev_q) | (inv_q != inv_prev_q);
    assign upd = (state_q == StCheck) & ~chg & check_en_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q          <= '0;
            b_q          <= '0;
            inv_q        <= 1'b0;
            a_prev_q     <= '0;
            inv_prev_q   <= 1'b0;
            diff_q       <= '0;
            err_sticky_q <= '0;
            err_count_q  <= '0;
            cnt_q        <= '0;
            state_q      <= StIdle;
        end else begin
            a_q          <= a_i;
            b_q          <= b_i;
            inv_q        <= invert_i;
            a_prev_q     <= a_q;
            inv_prev_q   <= inv_q;
            diff_q       <= m;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (SETTLE == 0) begin
                    state_d = StCheck;
                end else begin
                    state_d = StSettle;
                    cnt_d   = LoadIdle;
                end
            end
            StSettle: begin
                if (chg) begin
                    if (SETTLE > 1) cnt_d = LoadChg;
                    else state_d = StCheck;
                end else if (cnt_q == '0) begin
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StCheck: begin
                if (chg && (SETTLE > 1)) begin
                    state_d = StSettle;
                    cnt_d   = LoadChg;
                end
            end
            default: state_d = StIdle;
        endcase
        if (!check_en_i) state_d = StIdle;
    end

    always_comb begin
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;
        if (clear_i) begin
            err_sticky_d = '0;
            err_count_d  = '0;
        end else if (upd) begin
            err_sticky_d = err_sticky_q | m;
            if ((|m) && (err_count_q != CountMax)) err_count_d = err_count_q + CNT_W'(1);
        end
    end

`ifdef COMPARE_FIRST_FAIL_EN
    logic             ff_valid_q;
    logic [WIDTH-1:0] ff_a_q, ff_diff_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ff_valid_q <= 1'b0;
            ff_a_q     <= '0;
            ff_diff_q  <= '0;
        end else if (clear_i) begin
            ff_valid_q <= 1'b0;
            ff_a_q     <= '0;
            ff_diff_q  <= '0;
        end else if (upd && (|m) && !ff_valid_q) begin
            ff_valid_q <= 1'b1;
            ff_a_q     <= a_q;
            ff_diff_q  <= m;
        end
    end

    assign ff_valid_o = ff_valid_q;
    assign ff_a_o     = ff_a_q;
    assign ff_diff_o  = ff_diff_q;
`else
    assign ff_valid_o = 1'b0;
    assign ff_a_o     = '0;
    assign ff_diff_o  = '0;
`endif

    assign diff_o       = diff_q;
    assign err_sticky_o = err_sticky_q;
    assign fail_o       = |err_sticky_q;
    assign err_count_o  = err_count_q;
    assign checking_o   = (state_q == StCheck);

endmodule
